multicycle_control: RTL and testbench

Parametrised multi-cycle control FSM that sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK instead of decoding it in a single combinational step. It sits between the instruction register, the PC logic, the ALU and the register file. It handshakes with instruction and data memory, which may have variable latency. It adds a front-end stall, an optional illegal-opcode trap and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences each instruction through FETCH, DECODE, EXECUTE,
// MEM and WRITEBACK with variable-latency memory handshakes, stall, trap and retire count.
module multicycle_control #(
    parameter int OPCODE_W     = 6,
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                stall,
    output logic                instr_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_op,
    output logic                alu_src,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                beq,
    output logic                bne,
    output logic                jump,
    output logic                retire,
    output logic [CNT_W-1:0]    instr_count,
    output logic                illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_LW,
        C_SW,
        C_DP,
        C_BEQ,
        C_BNE,
        C_J,
        C_ILL
    } class_t;

    state_t             state;
    class_t             cls;
    class_t             dec_cls;
    logic [CNT_W-1:0]   cnt;
    logic               ill;

    function automatic class_t decode_class(input logic [OPCODE_W-1:0] op);
        class_t c;
        if (op == OPCODE_W'(0))
            c = C_LW;
        else if (op == OPCODE_W'(1))
            c = C_SW;
        else if ((op >= OPCODE_W'(2)) && (op <= OPCODE_W'(9)))
            c = C_DP;
        else if (op == OPCODE_W'(11))
            c = C_BEQ;
        else if (op == OPCODE_W'(12))
            c = C_BNE;
        else if (op == OPCODE_W'(13))
            c = C_J;
        else
            c = ILLEGAL_TRAP ? C_ILL : C_DP;
        return c;
    endfunction

    always_comb dec_cls = decode_class(opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            cls   <= C_DP;
            cnt   <= '0;
            ill   <= 1'b0;
        end else begin
            if (retire)
                cnt <= cnt + CNT_W'(1);
            case (state)
                S_FETCH: begin
                    if (!stall && imem_ready)
                        state <= S_DECODE;
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    if (dec_cls == C_ILL) begin
                        state <= S_TRAP;
                        ill   <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (cls)
                        C_LW, C_SW: state <= S_MEM;
                        C_DP:       state <= S_WRITEBACK;
                        default:    state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready)
                        state <= (cls == C_LW) ? S_WRITEBACK : S_FETCH;
                end
                S_WRITEBACK: state <= S_FETCH;
                S_TRAP:      state <= S_TRAP;
                default:     state <= S_FETCH;
            endcase
        end
    end

    // Control outputs decode the current state directly so handshakes complete in the ready cycle.
    always_comb begin
        instr_req  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        jump       = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    if (!stall) begin
                        instr_req = 1'b1;
                        ir_write  = imem_ready;
                        pc_write  = imem_ready;
                    end
                end
                S_EXECUTE: begin
                    case (cls)
                        C_LW, C_SW: begin
                            alu_op  = 2'b10;
                            alu_src = 1'b1;
                        end
                        C_BEQ: begin
                            alu_op   = 2'b01;
                            beq      = 1'b1;
                            pc_src   = 2'b01;
                            pc_write = zero;
                            retire   = 1'b1;
                        end
                        C_BNE: begin
                            alu_op   = 2'b01;
                            bne      = 1'b1;
                            pc_src   = 2'b01;
                            pc_write = !zero;
                            retire   = 1'b1;
                        end
                        C_J: begin
                            jump     = 1'b1;
                            pc_src   = 2'b10;
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    alu_op    = 2'b10;
                    alu_src   = 1'b1;
                    mem_read  = (cls == C_LW);
                    mem_write = (cls == C_SW);
                    retire    = (cls == C_SW) && dmem_ready;
                end
                S_WRITEBACK: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls == C_LW);
                    reg_dst    = (cls != C_LW);
                    retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_count = rst ? '0 : cnt;
    assign illegal_op  = ill & ~rst;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: per-instruction expected cycle sequences are
// built from the opcode-class rules and compared cycle by cycle on two configurations.
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, zero_a, imem_ready_a, dmem_ready_a, stall_a;
    logic [5:0] opcode_a;
    logic       rst_b, zero_b, imem_ready_b, dmem_ready_b, stall_b;
    logic [5:0] opcode_b;

    logic        instr_req_a, ir_write_a, pc_write_a, alu_src_a, reg_dst_a, mem_to_reg_a;
    logic        mem_read_a, mem_write_a, reg_write_a, beq_a, bne_a, jump_a, retire_a, illegal_op_a;
    logic [1:0]  pc_src_a, alu_op_a;
    logic [31:0] instr_count_a;
    logic        instr_req_b, ir_write_b, pc_write_b, alu_src_b, reg_dst_b, mem_to_reg_b;
    logic        mem_read_b, mem_write_b, reg_write_b, beq_b, bne_b, jump_b, retire_b, illegal_op_b;
    logic [1:0]  pc_src_b, alu_op_b;
    logic [3:0]  instr_count_b;

    multicycle_control #(.OPCODE_W(6), .CNT_W(32), .ILLEGAL_TRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .opcode(opcode_a), .zero(zero_a),
        .imem_ready(imem_ready_a), .dmem_ready(dmem_ready_a), .stall(stall_a),
        .instr_req(instr_req_a), .ir_write(ir_write_a), .pc_write(pc_write_a),
        .pc_src(pc_src_a), .alu_op(alu_op_a), .alu_src(alu_src_a), .reg_dst(reg_dst_a),
        .mem_to_reg(mem_to_reg_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .reg_write(reg_write_a), .beq(beq_a), .bne(bne_a), .jump(jump_a),
        .retire(retire_a), .instr_count(instr_count_a), .illegal_op(illegal_op_a)
    );

    multicycle_control #(.OPCODE_W(6), .CNT_W(4), .ILLEGAL_TRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .opcode(opcode_b), .zero(zero_b),
        .imem_ready(imem_ready_b), .dmem_ready(dmem_ready_b), .stall(stall_b),
        .instr_req(instr_req_b), .ir_write(ir_write_b), .pc_write(pc_write_b),
        .pc_src(pc_src_b), .alu_op(alu_op_b), .alu_src(alu_src_b), .reg_dst(reg_dst_b),
        .mem_to_reg(mem_to_reg_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .reg_write(reg_write_b), .beq(beq_b), .bne(bne_b), .jump(jump_b),
        .retire(retire_b), .instr_count(instr_count_b), .illegal_op(illegal_op_b)
    );

    logic [17:0] obs_a, obs_b;
    assign obs_a = {instr_req_a, ir_write_a, pc_write_a, pc_src_a, alu_op_a, alu_src_a,
                    reg_dst_a, mem_to_reg_a, mem_read_a, mem_write_a, reg_write_a,
                    beq_a, bne_a, jump_a, retire_a, illegal_op_a};
    assign obs_b = {instr_req_b, ir_write_b, pc_write_b, pc_src_b, alu_op_b, alu_src_b,
                    reg_dst_b, mem_to_reg_b, mem_read_b, mem_write_b, reg_write_b,
                    beq_b, bne_b, jump_b, retire_b, illegal_op_b};

    localparam logic [17:0] E_IREQ  = 18'b1 << 17;
    localparam logic [17:0] E_IRW   = 18'b1 << 16;
    localparam logic [17:0] E_PCW   = 18'b1 << 15;
    localparam logic [17:0] E_PCS_J = 18'b1 << 14;
    localparam logic [17:0] E_PCS_B = 18'b1 << 13;
    localparam logic [17:0] E_ALU_M = 18'b1 << 12;
    localparam logic [17:0] E_ALU_B = 18'b1 << 11;
    localparam logic [17:0] E_ASRC  = 18'b1 << 10;
    localparam logic [17:0] E_RDST  = 18'b1 << 9;
    localparam logic [17:0] E_M2R   = 18'b1 << 8;
    localparam logic [17:0] E_MRD   = 18'b1 << 7;
    localparam logic [17:0] E_MWR   = 18'b1 << 6;
    localparam logic [17:0] E_RW    = 18'b1 << 5;
    localparam logic [17:0] E_BEQ   = 18'b1 << 4;
    localparam logic [17:0] E_BNE   = 18'b1 << 3;
    localparam logic [17:0] E_JMP   = 18'b1 << 2;
    localparam logic [17:0] E_RET   = 18'b1 << 1;
    localparam logic [17:0] E_ILL   = 18'b1;

    typedef enum {K_LW, K_SW, K_DP, K_BEQ, K_BNE, K_J, K_ILL} kind_t;

    typedef struct {
        bit          st;
        bit          ir;
        bit          dr;
        bit          z;
        bit          rop;
        logic [17:0] e;
    } cyc_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cnt_m [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic kind_t classify(input int unsigned op, input bit trap);
        if (op == 0) return K_LW;
        if (op == 1) return K_SW;
        if (op >= 2 && op <= 9) return K_DP;
        if (op == 11) return K_BEQ;
        if (op == 12) return K_BNE;
        if (op == 13) return K_J;
        return trap ? K_ILL : K_DP;
    endfunction

    task automatic drive(input bit which, input bit r, input logic [5:0] op,
                         input bit z, input bit ir, input bit dr, input bit st);
        if (which) begin
            rst_b = r; opcode_b = op; zero_b = z; imem_ready_b = ir; dmem_ready_b = dr; stall_b = st;
        end else begin
            rst_a = r; opcode_a = op; zero_a = z; imem_ready_a = ir; dmem_ready_a = dr; stall_a = st;
        end
    endtask

    function automatic logic [31:0] count_of(input bit which);
        return which ? 32'(instr_count_b) : instr_count_a;
    endfunction

    function automatic logic [31:0] count_exp(input bit which);
        return which ? (cnt_m[1] % 16) : cnt_m[0];
    endfunction

    task automatic do_reset(input bit which);
        for (int i = 0; i < 2; i++) begin
            drive(which, 1'b1, 6'($urandom), rb(), rb(), rb(), rb());
            @(negedge clk);
            check($sformatf("rst_ctl%0d", which), 32'(which ? obs_b : obs_a), 32'd0);
            check($sformatf("rst_cnt%0d", which), count_of(which), 32'd0);
            @(posedge clk); #1;
        end
        cnt_m[which] = 0;
        drive(which, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_instr(input bit which, input int unsigned op, input bit z,
                             input int unsigned nstall, input int unsigned iwait,
                             input int unsigned dwait, input bit rst_mid);
        cyc_t  q[$];
        cyc_t  c;
        kind_t k;
        k = classify(op, which == 1'b0);
        for (int i = 0; i < int'(nstall); i++) begin
            c = '{st: 1, ir: 1, dr: rb(), z: rb(), rop: 0, e: '0};
            q.push_back(c);
        end
        for (int i = 0; i < int'(iwait); i++) begin
            c = '{st: 0, ir: 0, dr: rb(), z: rb(), rop: 0, e: E_IREQ};
            q.push_back(c);
        end
        c = '{st: 0, ir: 1, dr: rb(), z: rb(), rop: 0, e: E_IREQ | E_IRW | E_PCW};
        q.push_back(c);
        c = '{st: rb(), ir: rb(), dr: rb(), z: rb(), rop: 0, e: '0};
        q.push_back(c);
        if (k == K_ILL) begin
            for (int i = 0; i < 20; i++) begin
                c = '{st: rb(), ir: rb(), dr: rb(), z: rb(), rop: 1, e: E_ILL};
                q.push_back(c);
            end
        end else begin
            c = '{st: rb(), ir: rb(), dr: rb(), z: z, rop: 1, e: '0};
            case (k)
                K_LW, K_SW: c.e = E_ALU_M | E_ASRC;
                K_BEQ:      c.e = E_BEQ | E_ALU_B | E_PCS_B | E_RET | (z ? E_PCW : '0);
                K_BNE:      c.e = E_BNE | E_ALU_B | E_PCS_B | E_RET | (z ? '0 : E_PCW);
                K_J:        c.e = E_JMP | E_PCS_J | E_PCW | E_RET;
                default:    c.e = '0;
            endcase
            q.push_back(c);
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i < (rst_mid ? 2 : int'(dwait)); i++) begin
                    c = '{st: rb(), ir: rb(), dr: 0, z: rb(), rop: 1,
                          e: E_ALU_M | E_ASRC | ((k == K_LW) ? E_MRD : E_MWR)};
                    q.push_back(c);
                end
                if (!rst_mid) begin
                    c = '{st: rb(), ir: rb(), dr: 1, z: rb(), rop: 1,
                          e: E_ALU_M | E_ASRC | ((k == K_LW) ? E_MRD : (E_MWR | E_RET))};
                    q.push_back(c);
                end
            end
            if ((k == K_LW && !rst_mid) || k == K_DP) begin
                c = '{st: rb(), ir: rb(), dr: rb(), z: rb(), rop: 1,
                      e: E_RW | E_RET | ((k == K_LW) ? E_M2R : E_RDST)};
                q.push_back(c);
            end
        end
        foreach (q[i]) begin
            drive(which, 1'b0, q[i].rop ? 6'($urandom) : 6'(op), q[i].z, q[i].ir, q[i].dr, q[i].st);
            @(negedge clk);
            check($sformatf("ctl%0d op%0d c%0d", which, op, i), 32'(which ? obs_b : obs_a), 32'(q[i].e));
            check($sformatf("cnt%0d op%0d c%0d", which, op, i), count_of(which), count_exp(which));
            @(posedge clk); #1;
            if (q[i].e[1]) cnt_m[which]++;
        end
        drive(which, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (k == K_ILL || rst_mid) do_reset(which);
    endtask

    task automatic run_random(input bit which);
        int unsigned ops [12] = '{0, 1, 2, 5, 9, 10, 11, 12, 13, 14, 15, 63};
        run_instr(which, ops[$urandom_range(0, 11)], rb(), $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        @(posedge clk); #1;
        do_reset(0);
        do_reset(1);

        run_instr(0, 2, 1'b0, 0, 0, 0, 1'b0);
        check("dp_count", instr_count_a, 32'd1);
        run_instr(0, 0, 1'b0, 0, 0, 3, 1'b0);
        run_instr(0, 11, 1'b1, 0, 0, 0, 1'b0);
        run_instr(0, 11, 1'b0, 0, 0, 0, 1'b0);
        run_instr(0, 12, 1'b1, 0, 0, 0, 1'b0);
        run_instr(0, 12, 1'b0, 0, 0, 0, 1'b0);
        run_instr(0, 13, 1'b0, 0, 1, 0, 1'b0);
        run_instr(0, 1, 1'b0, 0, 0, 2, 1'b0);
        run_instr(0, 3, 1'b0, 5, 0, 0, 1'b0);
        run_instr(0, 14, 1'b0, 0, 0, 0, 1'b0);
        run_instr(0, 4, 1'b1, 0, 0, 0, 1'b0);
        run_instr(1, 14, 1'b0, 0, 0, 0, 1'b0);
        run_instr(0, 0, 1'b0, 1, 1, 5, 1'b1);
        run_instr(0, 6, 1'b0, 0, 0, 0, 1'b0);

        do_reset(1);
        repeat (17) run_random(1);
        check("wrap", 32'(instr_count_b), 32'd1);

        repeat (150) begin
            run_random(0);
            run_random(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
